// File: rtl/router_pkg.sv
// Shared constants and types for the router destination-side buffer bank.
package router_pkg;

  localparam int ROUTER_NUM_CH  = 3;
  localparam int ROUTER_DW      = 8;
  localparam int ROUTER_DEPTH   = 16;
  localparam int ROUTER_TIMEOUT = 30;

  // One stored FIFO word: header tag alongside the payload byte.
  typedef struct packed {
    logic                 hdr;
    logic [ROUTER_DW-1:0] data;
  } entry_t;

  // Bits needed to hold any value in 0..max_val (inclusive).
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int ROUTER_CNT_W = cnt_width(ROUTER_DEPTH);

endpackage

// File: rtl/router_chan_fifo.sv
// One destination channel: circular FIFO of {hdr, data} words plus a read
// timeout that flushes the channel when the destination stops servicing it.
module router_chan_fifo
  import router_pkg::*;
#(
  parameter int DW      = ROUTER_DW,
  parameter int DEPTH   = ROUTER_DEPTH,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_write_enb,
  input  logic [DW-1:0] i_data_in,
  input  logic          i_lfd,
  input  logic          i_read_enb,
  output logic [DW-1:0] o_data_out,
  output logic          o_hdr_out,
  output logic          o_valid_out,
  output logic          o_full,
  output logic          o_soft_reset
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam int TW = cnt_width(TIMEOUT);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic          hdr;
    logic [DW-1:0] data;
  } chan_entry_t;

  chan_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_data_out;
  logic          r_hdr_out;
  logic          r_soft_reset;

  logic          w_valid;
  logic          w_full;
  logic          w_idle;
  logic          w_flush;
  logic          w_do_wr;
  logic          w_do_rd;
  logic [CW-1:0] w_count_next;
  chan_entry_t   w_head;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_FULL);
  // Idle means data is waiting and the destination is not taking it.
  assign w_idle  = w_valid && !i_read_enb;
  assign w_flush = w_idle && (r_timer == TMR_LAST);
  // full is judged on the pre-read count, so a full channel drops a
  // simultaneous write even though a read frees a slot on the same edge.
  assign w_do_wr = i_write_enb && !w_full && !w_flush;
  assign w_do_rd = i_read_enb && w_valid;
  assign w_head  = r_mem[r_rd_ptr];

  // Occupancy after this edge's accepted read/write.
  always_comb begin
    // NOTE: assign the default first so every path drives the signal and no latch is inferred.
    w_count_next = r_count;
    if (w_do_wr && !w_do_rd) begin
      w_count_next = r_count + CNT_ONE;
    end else if (!w_do_wr && w_do_rd) begin
      w_count_next = r_count - CNT_ONE;
    end
  end

  // Storage write; an entry is live only while the pointers say so.
  always_ff @(posedge i_clock) begin
    // NOTE: the array has no reset; clearing it buys nothing and blocks RAM mapping.
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= '{hdr: i_lfd, data: i_data_in};
    end
  end

  // Pointers, occupancy, timeout timer and registered read port.
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_timer      <= '0;
      r_data_out   <= '0;
      r_hdr_out    <= 1'b0;
      r_soft_reset <= 1'b0;
    end else begin
      r_soft_reset <= w_flush;
      if (w_flush) begin
        // Abandon the channel's contents; the last read data stays visible.
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_timer  <= '0;
      end else begin
        if (w_do_wr) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_do_rd) begin
          r_rd_ptr   <= r_rd_ptr + PTR_ONE;
          r_data_out <= w_head.data;
          r_hdr_out  <= w_head.hdr;
        end
        r_count <= w_count_next;
        r_timer <= w_idle ? (r_timer + TMR_ONE) : '0;
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_hdr_out    = r_hdr_out;
  assign o_valid_out  = w_valid;
  assign o_full       = w_full;
  assign o_soft_reset = r_soft_reset;

endmodule

// File: rtl/router_dst_buffer.sv
// Destination-side buffer bank: one independent FIFO per output channel,
// all fed from the shared router write bus.
module router_dst_buffer
  import router_pkg::*;
#(
  parameter int NUM_CH  = ROUTER_NUM_CH,
  parameter int DW      = ROUTER_DW,
  parameter int DEPTH   = ROUTER_DEPTH,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          write_enb,
  input  logic [DW-1:0]              data_in,
  input  logic                       lfd,
  input  logic [NUM_CH-1:0]          read_enb,
  output logic [NUM_CH-1:0][DW-1:0]  data_out,
  output logic [NUM_CH-1:0]          valid_out,
  output logic [NUM_CH-1:0]          full,
  output logic [NUM_CH-1:0]          soft_reset,
  output logic [NUM_CH-1:0]          hdr_out
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    router_chan_fifo #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
    ) u_fifo (
      .i_clock      (clock),
      .i_reset      (reset),
      .i_write_enb  (write_enb[gi]),
      .i_data_in    (data_in),
      .i_lfd        (lfd),
      .i_read_enb   (read_enb[gi]),
      .o_data_out   (data_out[gi]),
      .o_hdr_out    (hdr_out[gi]),
      .o_valid_out  (valid_out[gi]),
      .o_full       (full[gi]),
      .o_soft_reset (soft_reset[gi])
    );
  end

endmodule

// File: tb/tb_router_dst_buffer.sv
// Self-checking bench for router_dst_buffer: queue-based reference model,
// per-cycle output comparison, directed scenarios and a random phase.
module tb_router_dst_buffer;
  import router_pkg::*;

  localparam int NUM_CH  = ROUTER_NUM_CH;
  localparam int DW      = ROUTER_DW;
  localparam int DEPTH   = ROUTER_DEPTH;
  localparam int TIMEOUT = ROUTER_TIMEOUT;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_CH-1:0]         write_enb;
  logic [DW-1:0]             data_in;
  logic                      lfd;
  logic [NUM_CH-1:0]         read_enb;
  logic [NUM_CH-1:0][DW-1:0] data_out;
  logic [NUM_CH-1:0]         valid_out;
  logic [NUM_CH-1:0]         full;
  logic [NUM_CH-1:0]         soft_reset;
  logic [NUM_CH-1:0]         hdr_out;

  always #5 clock = ~clock;

  router_dst_buffer #(
    .NUM_CH (NUM_CH), .DW (DW), .DEPTH (DEPTH), .TIMEOUT (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .write_enb  (write_enb),
    .data_in    (data_in),
    .lfd        (lfd),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .full       (full),
    .soft_reset (soft_reset),
    .hdr_out    (hdr_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  entry_t        m_q    [NUM_CH][$];
  int            m_idle [NUM_CH];
  logic [DW-1:0] m_data [NUM_CH];
  logic          m_hdr  [NUM_CH];
  logic          m_soft [NUM_CH];
  bit            m_live = 1'b0;

  always @(posedge clock) begin
    bit     ne, fl, idle;
    entry_t e;
    if (reset) begin
      m_live = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_q[i].delete();
        m_idle[i] = 0;
        m_data[i] = '0;
        m_hdr[i]  = 1'b0;
        m_soft[i] = 1'b0;
      end
    end else if (m_live) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ne   = (m_q[i].size() != 0);
        fl   = (m_q[i].size() == DEPTH);
        idle = ne && !read_enb[i];
        m_soft[i] = idle && (m_idle[i] == TIMEOUT - 1);
        if (m_soft[i]) begin
          m_q[i].delete();
          m_idle[i] = 0;
        end else begin
          if (read_enb[i] && ne) begin
            e = m_q[i].pop_front();
            m_data[i] = e.data;
            m_hdr[i]  = e.hdr;
          end
          if (write_enb[i] && !fl) m_q[i].push_back('{hdr: lfd, data: data_in});
          m_idle[i] = idle ? m_idle[i] + 1 : 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (m_live) begin
      for (int i = 0; i < NUM_CH; i++) begin
        check($sformatf("ch%0d valid_out", i), 64'(valid_out[i]), 64'(m_q[i].size() != 0));
        check($sformatf("ch%0d full", i), 64'(full[i]), 64'(m_q[i].size() == DEPTH));
        check($sformatf("ch%0d data_out", i), 64'(data_out[i]), 64'(m_data[i]));
        check($sformatf("ch%0d hdr_out", i), 64'(hdr_out[i]), 64'(m_hdr[i]));
        check($sformatf("ch%0d soft_reset", i), 64'(soft_reset[i]), 64'(m_soft[i]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int ch, input logic [DW-1:0] d, input logic h);
    write_enb     = '0;
    write_enb[ch] = 1'b1;
    data_in       = d;
    lfd           = h;
    tick();
    write_enb = '0;
    lfd       = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    write_enb = '0;
    read_enb  = '0;
    data_in   = '0;
    lfd       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset valid_out", 64'(valid_out), 64'(0));
    check("reset data_out", 64'(data_out), 64'(0));
    check("reset soft_reset", 64'(soft_reset), 64'(0));

    // Header-tagged packet through channel 0.
    wr(0, 8'h05, 1'b1);
    wr(0, 8'hA1, 1'b0);
    wr(0, 8'hB2, 1'b0);
    read_enb[0] = 1'b1;
    tick();
    check("t1 data 05", 64'(data_out[0]), 64'h05);
    check("t1 hdr 05", 64'(hdr_out[0]), 64'h1);
    tick();
    check("t1 data A1", 64'(data_out[0]), 64'hA1);
    check("t1 hdr A1", 64'(hdr_out[0]), 64'h0);
    tick();
    check("t1 data B2", 64'(data_out[0]), 64'hB2);
    check("t1 valid after drain", 64'(valid_out[0]), 64'h0);
    read_enb = '0;
    check("t1 others untouched", 64'(valid_out[2:1]), 64'h0);

    // Fill channel 1, overflow write dropped.
    for (int k = 0; k < DEPTH; k++) wr(1, DW'(k), k == 0);
    wr(1, 8'hFF, 1'b0);
    check("t2 full", 64'(full[1]), 64'h1);
    check("t2 model depth", 64'(m_q[1].size()), 64'(DEPTH));
    read_enb[1] = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      check($sformatf("t2 read %0d", k), 64'(data_out[1]), 64'(k));
    end
    read_enb = '0;
    check("t2 empty", 64'(valid_out[1]), 64'h0);

    // Timeout flush on channel 2: idle counting starts at the second write.
    for (int k = 0; k < 4; k++) wr(2, DW'(8'hC0 + k), k == 0);
    repeat (26) tick();
    check("t3 no early flush", 64'(soft_reset[2]), 64'h0);
    check("t3 still valid", 64'(valid_out[2]), 64'h1);
    tick();
    check("t3 soft_reset pulse", 64'(soft_reset[2]), 64'h1);
    check("t3 flushed", 64'(valid_out[2]), 64'h0);
    tick();
    check("t3 pulse one cycle", 64'(soft_reset[2]), 64'h0);

    // Read rescues channel 0 at idle count 29.
    wr(0, 8'h11, 1'b1);
    wr(0, 8'h22, 1'b0);
    repeat (28) tick();
    read_enb[0] = 1'b1;
    tick();
    check("t4 data 11", 64'(data_out[0]), 64'h11);
    check("t4 no soft_reset", 64'(soft_reset[0]), 64'h0);
    tick();
    check("t4 data 22", 64'(data_out[0]), 64'h22);
    read_enb = '0;
    tick();
    check("t4 still no soft_reset", 64'(soft_reset[0]), 64'h0);

    // Simultaneous read/write on full, then on empty.
    for (int k = 0; k < DEPTH; k++) wr(0, DW'(8'h40 + k), k == 0);
    check("t5 full", 64'(full[0]), 64'h1);
    write_enb[0] = 1'b1;
    read_enb[0]  = 1'b1;
    data_in      = 8'h77;
    tick();
    write_enb = '0;
    check("t5 oldest out", 64'(data_out[0]), 64'h40);
    check("t5 not full", 64'(full[0]), 64'h0);
    check("t5 model count 15", 64'(m_q[0].size()), 64'(DEPTH - 1));
    for (int k = 1; k < DEPTH; k++) begin
      tick();
      check($sformatf("t5 drain %0d", k), 64'(data_out[0]), 64'(8'h40 + k));
    end
    check("t5 77 dropped", 64'(valid_out[0]), 64'h0);
    write_enb[0] = 1'b1;
    data_in      = 8'h33;
    tick();
    write_enb = '0;
    read_enb  = '0;
    check("t5 empty rw hold", 64'(data_out[0]), 64'h4F);
    check("t5 empty rw valid", 64'(valid_out[0]), 64'h1);
    read_enb[0] = 1'b1;
    tick();
    read_enb = '0;
    check("t5 read 33", 64'(data_out[0]), 64'h33);

    // Reset mid-packet.
    for (int k = 0; k < 5; k++) wr(1, DW'(8'h90 + k), k == 0);
    reset = 1'b1;
    tick();
    check("t6 data_out", 64'(data_out), 64'h0);
    check("t6 hdr_out", 64'(hdr_out), 64'h0);
    check("t6 valid_out", 64'(valid_out), 64'h0);
    check("t6 full", 64'(full), 64'h0);
    reset = 1'b0;
    repeat (3) tick();
    check("t6 no soft_reset", 64'(soft_reset), 64'h0);
    check("t6 stays empty", 64'(valid_out), 64'h0);

    // Random phase: alternate well-serviced and starved windows.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int p;
      p = ((cyc / 250) % 2 == 0) ? 50 : 3;
      write_enb = NUM_CH'($urandom);
      for (int i = 0; i < NUM_CH; i++) read_enb[i] = ($urandom_range(99) < p);
      data_in = DW'($urandom);
      lfd     = 1'($urandom);
      reset   = ($urandom_range(399) == 0);
      tick();
    end
    reset     = 1'b0;
    write_enb = '0;
    read_enb  = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
